// File: rtl/acl_arbiter_pkg.sv
// acl_arbiter_pkg: shared command codes, arbiter states and constants for the ACL2 command arbiter
package acl_arbiter_pkg;
    typedef enum logic [2:0] {
        CMD_NONE         = 3'd0,
        CMD_INIT_MEASUR  = 3'd1,
        CMD_START_MEASUR = 3'd2,
        CMD_INIT_LINKED  = 3'd3,
        CMD_START_LINKED = 3'd4
    } t_acl_cmd;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_BUSY, ST_SRST} t_arb_state;
    localparam int c_srst_min_cycles = 2;
    function automatic logic cmd_is_legal(input logic [2:0] code);
        return code inside {[3'd1:3'd4]};
    endfunction
endpackage

// File: rtl/acl_rr_picker.sv
// acl_rr_picker: first set bit of a valid mask, searching upward from a rotating pointer with wrap
module acl_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IW-1:0]      rr_ptr,
    output logic               found,
    output logic [IW-1:0]      idx
);
    logic [IW-1:0] j;
    // scan from the far end back toward rr_ptr so the nearest hit overwrites the others
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = IW'((int'(rr_ptr) + i) % NUM_REQ);
            if (valid[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end
endmodule

// File: rtl/acl_command_arbiter.sv
// acl_command_arbiter: round-robin sharing of the PMOD ACL2 driver command interface with preemptive soft reset
module acl_command_arbiter
    import acl_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int CNT_BITS       = 21
) (
    input  logic                 i_clk_20mhz,
    input  logic                 i_rst_20mhz,
    input  logic                 i_acl_command_ready,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [3*NUM_REQ-1:0] i_req_cmd,
    input  logic [NUM_REQ-1:0]   i_soft_reset_req,
    output logic [NUM_REQ-1:0]   o_req_grant,
    output logic [NUM_REQ-1:0]   o_req_done,
    output logic [NUM_REQ-1:0]   o_req_error,
    output logic                 o_acl_cmd_init_measur_mode,
    output logic                 o_acl_cmd_start_measur_mode,
    output logic                 o_acl_cmd_init_linked_mode,
    output logic                 o_acl_cmd_start_linked_mode,
    output logic                 o_acl_cmd_soft_reset,
    output logic                 o_arb_busy
);
    localparam int IW = (NUM_REQ > 2) ? 2 : 1;

    t_arb_state          state, state_d;
    t_acl_cmd            code, code_d;
    logic [IW-1:0]       owner, owner_d, rr_ptr, rr_ptr_d, pick_idx;
    logic [CNT_BITS-1:0] cnt, cnt_d;
    logic [NUM_REQ-1:0]  srst_mask, srst_mask_d, grant_d, done_d, error_d;
    logic [2:0]          cmds [NUM_REQ];
    logic [2:0]          pick_cmd;
    logic                pick_found, settle, timeout, srst_any, active, active_d;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] k);
        return (k == IW'(NUM_REQ - 1)) ? '0 : k + 1'b1;
    endfunction

    acl_rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
        .valid  (i_req_valid),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    // unpack the per-requester command codes so the picked one can be indexed directly
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) cmds[k] = i_req_cmd[3*k +: 3];
    end

    assign pick_cmd = cmds[pick_idx];
    // a requester still sees its own done/error this cycle, so its request level is stale and ignored
    assign settle   = |{o_req_done, o_req_error};
    assign timeout  = cnt == CNT_BITS'(TIMEOUT_CYCLES - 1);
    assign srst_any = |i_soft_reset_req;
    assign active   = state == ST_ISSUE || state == ST_BUSY;
    assign active_d = state_d == ST_ISSUE || state_d == ST_BUSY;

    // next-state, ownership and result-pulse decisions
    always_comb begin
        state_d     = state;
        owner_d     = owner;
        code_d      = code;
        rr_ptr_d    = rr_ptr;
        srst_mask_d = srst_mask;
        done_d      = '0;
        error_d     = '0;
        case (state)
            ST_IDLE: begin
                if (!settle && srst_any) begin
                    srst_mask_d = i_soft_reset_req;
                    state_d     = ST_SRST;
                end else if (!settle && i_acl_command_ready && pick_found) begin
                    owner_d = pick_idx;
                    if (cmd_is_legal(pick_cmd)) begin
                        code_d  = t_acl_cmd'(pick_cmd);
                        state_d = ST_ISSUE;
                    end else begin
                        error_d  = NUM_REQ'(1) << pick_idx;
                        rr_ptr_d = wrap_inc(pick_idx);
                    end
                end
            end
            ST_ISSUE, ST_BUSY: begin
                if (srst_any) begin
                    error_d     = NUM_REQ'(1) << owner;
                    srst_mask_d = i_soft_reset_req;
                    state_d     = ST_SRST;
                end else if (state == ST_ISSUE && !i_acl_command_ready) begin
                    state_d = ST_BUSY;
                end else if (state == ST_BUSY && i_acl_command_ready) begin
                    done_d   = NUM_REQ'(1) << owner;
                    rr_ptr_d = wrap_inc(owner);
                    state_d  = ST_IDLE;
                end else if (timeout) begin
                    error_d = NUM_REQ'(1) << owner;
                    state_d = ST_IDLE;
                end
            end
            ST_SRST: begin
                if (cnt >= CNT_BITS'(c_srst_min_cycles - 1) && i_acl_command_ready) begin
                    done_d  = srst_mask;
                    state_d = ST_IDLE;
                end else if (timeout) begin
                    error_d = srst_mask;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cnt_d   = (state_d != state || state == ST_IDLE) ? '0 : cnt + 1'b1;
        grant_d = (active || active_d) ? NUM_REQ'(1) << owner_d : '0;
    end

    // state and registered outputs; grant stays up through the done/error cycle
    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            state                       <= ST_IDLE;
            code                        <= CMD_NONE;
            owner                       <= '0;
            rr_ptr                      <= '0;
            cnt                         <= '0;
            srst_mask                   <= '0;
            o_req_grant                 <= '0;
            o_req_done                  <= '0;
            o_req_error                 <= '0;
            o_acl_cmd_init_measur_mode  <= 1'b0;
            o_acl_cmd_start_measur_mode <= 1'b0;
            o_acl_cmd_init_linked_mode  <= 1'b0;
            o_acl_cmd_start_linked_mode <= 1'b0;
            o_acl_cmd_soft_reset        <= 1'b0;
            o_arb_busy                  <= 1'b0;
        end else begin
            state                       <= state_d;
            code                        <= code_d;
            owner                       <= owner_d;
            rr_ptr                      <= rr_ptr_d;
            cnt                         <= cnt_d;
            srst_mask                   <= srst_mask_d;
            o_req_grant                 <= grant_d;
            o_req_done                  <= done_d;
            o_req_error                 <= error_d;
            o_acl_cmd_init_measur_mode  <= state_d == ST_ISSUE && code_d == CMD_INIT_MEASUR;
            o_acl_cmd_start_measur_mode <= state_d == ST_ISSUE && code_d == CMD_START_MEASUR;
            o_acl_cmd_init_linked_mode  <= state_d == ST_ISSUE && code_d == CMD_INIT_LINKED;
            o_acl_cmd_start_linked_mode <= state_d == ST_ISSUE && code_d == CMD_START_LINKED;
            o_acl_cmd_soft_reset        <= state_d == ST_SRST;
            o_arb_busy                  <= state_d != ST_IDLE;
        end
    end
endmodule

// File: tb/tb_acl_command_arbiter.sv
// tb_acl_command_arbiter: scenario tasks with a scoreboard of expected done/error/grant events
module tb_acl_command_arbiter;
    localparam int NR = 2;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            ready = 1'b1;
    logic [NR-1:0]   valid = '0;
    logic [NR-1:0]   srst_req = '0;
    logic [3*NR-1:0] cmd = '0;
    logic [NR-1:0]   grant, done, err;
    logic            s_im, s_sm, s_il, s_sl, s_rst, busy;
    logic [3:0]      strobes, ev;
    logic [11:0]     all_outs;
    logic [3:0]      exp_q[$];
    int              n_checks = 0;
    int              n_fail = 0;

    assign strobes  = {s_im, s_sm, s_il, s_sl};
    assign ev       = {err, done};
    assign all_outs = {grant, done, err, strobes, s_rst, busy};

    always #25 clk = ~clk;

    acl_command_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO), .CNT_BITS(5)) dut (
        .i_clk_20mhz                 (clk),
        .i_rst_20mhz                 (rst),
        .i_acl_command_ready         (ready),
        .i_req_valid                 (valid),
        .i_req_cmd                   (cmd),
        .i_soft_reset_req            (srst_req),
        .o_req_grant                 (grant),
        .o_req_done                  (done),
        .o_req_error                 (err),
        .o_acl_cmd_init_measur_mode  (s_im),
        .o_acl_cmd_start_measur_mode (s_sm),
        .o_acl_cmd_init_linked_mode  (s_il),
        .o_acl_cmd_start_linked_mode (s_sl),
        .o_acl_cmd_soft_reset        (s_rst),
        .o_arb_busy                  (busy)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (all_outs !== 12'h0) begin n_fail++; $display("FAIL reset_hold: outputs=%h expected=%h", all_outs, 12'h0); end
        rst = 1'b0;
        tick();
        tick();
        n_checks++;
        if (all_outs !== 12'h0) begin n_fail++; $display("FAIL reset_idle: outputs=%h expected=%h", all_outs, 12'h0); end
    endtask

    task automatic test_single_cmd();
        int sc = 0;
        int bc = 0;
        bit got = 0;
        logic [3:0] e;
        ready = 1'b1;
        cmd[2:0] = 3'd1;
        valid = 2'b01;
        exp_q.push_back(4'b0001);
        for (int c = 0; c < 60 && !got; c++) begin
            tick();
            n_checks++;
            if (strobes !== 4'b1000 && strobes !== 4'b0000) begin n_fail++; $display("FAIL single_strobe_sel: strobes=%b expected=1000 or 0000", strobes); end
            if (s_im) begin
                sc++;
                if (sc == 3) ready = 1'b0;
            end else if (!ready) begin
                bc++;
                if (bc == 10) ready = 1'b1;
            end
            if (ev != 4'b0) begin
                got = 1;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
                n_checks++;
                if (ev !== e) begin n_fail++; $display("FAIL single_done: events=%b expected=%b", ev, e); end
                n_checks++;
                if (grant !== 2'b01) begin n_fail++; $display("FAIL single_grant_at_done: grant=%b expected=01", grant); end
                valid = 2'b00;
            end
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL single_done_timeout: done seen=0 expected=1"); end
        n_checks++;
        if (sc != 3) begin n_fail++; $display("FAIL single_strobe_len: cycles=%0d expected=3", sc); end
        tick();
        n_checks++;
        if ({grant, busy, ev} !== 7'b0) begin n_fail++; $display("FAIL single_release: grant/busy/events=%b expected=0000000", {grant, busy, ev}); end
    endtask

    // runs straight after test_single_cmd, whose done left the pointer at requester 1
    task automatic test_illegal();
        bit got = 0;
        logic [3:0] e;
        ready = 1'b1;
        cmd = {3'd7, 3'd2};
        valid = 2'b11;
        exp_q.push_back(4'b1000);
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (ev != 4'b0) begin
                got = 1;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
                n_checks++;
                if (ev !== e) begin n_fail++; $display("FAIL illegal_error: events=%b expected=%b", ev, e); end
                n_checks++;
                if ({grant, strobes} !== 6'b0) begin n_fail++; $display("FAIL illegal_no_grant: grant/strobes=%b expected=000000", {grant, strobes}); end
            end
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL illegal_error_timeout: error seen=0 expected=1"); end
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (grant != 2'b00) begin
                got = 1;
                n_checks++;
                if (grant !== 2'b01) begin n_fail++; $display("FAIL illegal_next_owner: grant=%b expected=01", grant); end
                n_checks++;
                if (strobes !== 4'b0100) begin n_fail++; $display("FAIL illegal_next_strobe: strobes=%b expected=0100", strobes); end
                valid = 2'b01;
                ready = 1'b0;
            end else if (ev != 4'b0) begin
                n_checks++;
                n_fail++;
                $display("FAIL illegal_repeat: events=%b expected=0000", ev);
            end
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL illegal_grant_timeout: grant seen=0 expected=1"); end
        exp_q.push_back(4'b0001);
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            if (c == 2) ready = 1'b1;
            if (ev != 4'b0) begin
                got = 1;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
                n_checks++;
                if (ev !== e) begin n_fail++; $display("FAIL illegal_followup_done: events=%b expected=%b", ev, e); end
                valid = 2'b00;
            end
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL illegal_followup_timeout: done seen=0 expected=1"); end
    endtask

    task automatic test_round_robin();
        int grants = 0;
        int bc = 0;
        logic [NR-1:0] prev = '0;
        logic [3:0] e;
        rst = 1'b1;
        valid = 2'b11;
        cmd = {3'd4, 3'd2};
        ready = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        for (int c = 0; c < 200 && grants < 4; c++) begin
            tick();
            if (grant != 2'b00 && prev == 2'b00) begin
                grants++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
                n_checks++;
                if ({2'b00, grant} !== e) begin n_fail++; $display("FAIL rr_grant_order: grant=%b expected=%b", grant, e[1:0]); end
            end
            if (strobes != 4'b0) begin
                n_checks++;
                if (strobes !== (grant[0] ? 4'b0100 : 4'b0001)) begin n_fail++; $display("FAIL rr_strobe: strobes=%b grant=%b expected=%b", strobes, grant, grant[0] ? 4'b0100 : 4'b0001); end
                ready = 1'b0;
                bc = 0;
            end else if (!ready) begin
                bc++;
                if (bc == 3) ready = 1'b1;
            end
            prev = grant;
        end
        valid = 2'b00;
        n_checks++;
        if (grants != 4) begin n_fail++; $display("FAIL rr_grant_count: grants=%0d expected=4", grants); end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (!ready) begin
                bc++;
                if (bc == 3) ready = 1'b1;
            end
        end
        n_checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin n_fail++; $display("FAIL rr_drain: busy=%b pending=%0d expected busy=0 pending=0", busy, exp_q.size()); end
    endtask

    task automatic test_soft_reset_preempt();
        bit got = 0;
        int hi;
        logic [3:0] e;
        ready = 1'b1;
        cmd = {3'd3, 3'd0};
        valid = 2'b10;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (strobes != 4'b0) begin
                got = 1;
                n_checks++;
                if (strobes !== 4'b0010) begin n_fail++; $display("FAIL srst_pre_strobe: strobes=%b expected=0010", strobes); end
                ready = 1'b0;
            end
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL srst_pre_timeout: strobe seen=0 expected=1"); end
        tick();
        tick();
        n_checks++;
        if ({grant, strobes, busy} !== 7'b1000001) begin n_fail++; $display("FAIL srst_pre_busy: grant/strobes/busy=%b expected=1000001", {grant, strobes, busy}); end
        srst_req = 2'b01;
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        tick();
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
        n_checks++;
        if (ev !== e) begin n_fail++; $display("FAIL srst_preempt_error: events=%b expected=%b", ev, e); end
        n_checks++;
        if ({strobes, s_rst} !== 5'b00001) begin n_fail++; $display("FAIL srst_level_on: strobes/soft_reset=%b expected=00001", {strobes, s_rst}); end
        valid = 2'b00;
        hi = 1;
        got = 0;
        for (int c = 0; c < 30 && !got; c++) begin
            tick();
            if (s_rst) hi++;
            if (hi == 3) ready = 1'b1;
            if (ev != 4'b0) begin
                got = 1;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
                n_checks++;
                if (ev !== e) begin n_fail++; $display("FAIL srst_done: events=%b expected=%b", ev, e); end
                srst_req = 2'b00;
            end
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL srst_done_timeout: done seen=0 expected=1"); end
        n_checks++;
        if (hi != 3) begin n_fail++; $display("FAIL srst_high_cycles: cycles=%0d expected=3", hi); end
        tick();
        n_checks++;
        if ({busy, s_rst, ev} !== 6'b0) begin n_fail++; $display("FAIL srst_absorbed: busy/soft_reset/events=%b expected=000000", {busy, s_rst, ev}); end
    endtask

    task automatic test_soft_reset_min();
        bit got = 0;
        int hi = 0;
        logic [3:0] e;
        ready = 1'b1;
        srst_req = 2'b10;
        exp_q.push_back(4'b0010);
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            if (s_rst) hi++;
            if (ev != 4'b0) begin
                got = 1;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
                n_checks++;
                if (ev !== e) begin n_fail++; $display("FAIL srst_min_done: events=%b expected=%b", ev, e); end
                srst_req = 2'b00;
            end
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL srst_min_timeout: done seen=0 expected=1"); end
        n_checks++;
        if (hi != 2) begin n_fail++; $display("FAIL srst_min_cycles: cycles=%0d expected=2", hi); end
    endtask

    task automatic test_timeout();
        bit got = 0;
        int n = 0;
        logic [3:0] e;
        ready = 1'b1;
        cmd[2:0] = 3'd1;
        valid = 2'b01;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (grant != 2'b00) got = 1;
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL timeout_grant: grant seen=0 expected=1"); end
        exp_q.push_back(4'b0100);
        got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            tick();
            n++;
            if (ev != 4'b0) begin
                got = 1;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
                n_checks++;
                if (ev !== e) begin n_fail++; $display("FAIL timeout_error: events=%b expected=%b", ev, e); end
                n_checks++;
                if (n != TO) begin n_fail++; $display("FAIL timeout_cycle: cycles after grant=%0d expected=%0d", n, TO); end
                n_checks++;
                if (strobes !== 4'b0) begin n_fail++; $display("FAIL timeout_strobe: strobes=%b expected=0000", strobes); end
                valid = 2'b00;
            end
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL timeout_missing: error seen=0 expected=1"); end
        tick();
        n_checks++;
        if ({grant, strobes, busy} !== 7'b0) begin n_fail++; $display("FAIL timeout_release: grant/strobes/busy=%b expected=0000000", {grant, strobes, busy}); end
    endtask

    task automatic test_async_reset();
        bit got = 0;
        logic [3:0] e;
        ready = 1'b1;
        cmd[2:0] = 3'd4;
        valid = 2'b01;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (strobes != 4'b0) begin got = 1; ready = 1'b0; end
        end
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b1 || grant !== 2'b01) begin n_fail++; $display("FAIL ar_busy: busy=%b grant=%b expected busy=1 grant=01", busy, grant); end
        #5 rst = 1'b1;
        #1;
        n_checks++;
        if (all_outs !== 12'h0) begin n_fail++; $display("FAIL ar_async_clear: outputs=%h expected=%h", all_outs, 12'h0); end
        tick();
        rst = 1'b0;
        ready = 1'b1;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (grant != 2'b00) begin
                got = 1;
                n_checks++;
                if ({grant, strobes} !== 6'b010001) begin n_fail++; $display("FAIL ar_regrant: grant/strobes=%b expected=010001", {grant, strobes}); end
                ready = 1'b0;
            end
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL ar_regrant_timeout: grant seen=0 expected=1"); end
        exp_q.push_back(4'b0001);
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            if (c == 2) ready = 1'b1;
            if (ev != 4'b0) begin
                got = 1;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
                n_checks++;
                if (ev !== e) begin n_fail++; $display("FAIL ar_done: events=%b expected=%b", ev, e); end
                valid = 2'b00;
            end
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL ar_done_timeout: done seen=0 expected=1"); end
    endtask

    initial begin
        test_reset();
        test_single_cmd();
        test_illegal();
        test_round_robin();
        test_soft_reset_preempt();
        test_soft_reset_min();
        test_timeout();
        test_async_reset();
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish before %0t", $time, 1_000_000);
        $fatal(1, "watchdog expired");
    end
endmodule
